// File: rtl/systolic_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : systolic_pkg
// Brief  : Types shared by the systolic array controller and result serializer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package systolic_pkg;

    localparam int RES_W = 9;

    typedef logic [RES_W-1:0] res_t;

    typedef struct packed {
        res_t c11;
        res_t c12;
        res_t c21;
        res_t c22;
    } res_mat_t;

    typedef enum logic [1:0] {
        E11 = 2'd0,
        E12 = 2'd1,
        E21 = 2'd2,
        E22 = 2'd3
    } elem_e;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/systolic_result_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : systolic_result_serializer
// Brief  : Buffers 2x2 results from the systolic controller and streams them
//          out row-major, one element per valid/ready beat; flags dropped results.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module systolic_result_serializer
    import systolic_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            c11,
    input  logic [DATA_W-1:0]            c12,
    input  logic [DATA_W-1:0]            c21,
    input  logic [DATA_W-1:0]            c22,
    input  logic                         res_valid,
    input  logic                         clr_overflow,
    output logic [DATA_W-1:0]            m_data,
    output logic [1:0]                   m_idx,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);

    if (DEPTH < 1) begin : g_depth_check
        $error("systolic_result_serializer: DEPTH must be >= 1");
    end

    logic [DATA_W-1:0]  r_mem [DEPTH][4];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    elem_e              r_elem;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic w_pop_last;
    logic w_accept;
    logic w_wr_en;
    logic w_drop;
    logic w_beat;

    // Outputs decode straight from the registers; data is masked while idle
    // because slot storage is never reset.
    always_comb begin
        m_valid    = (r_count != '0);
        m_data     = '0;
        m_idx      = 2'd0;
        m_last     = 1'b0;
        if (m_valid) begin
            m_data = r_mem[r_rd_ptr][r_elem];
            m_idx  = r_elem;
            m_last = (r_elem == E22);
        end
        w_beat     = m_valid && m_ready;
        w_pop_last = w_beat && (r_elem == E22);
        w_accept   = (r_count < c_depth_cnt) || w_pop_last;
        w_wr_en    = res_valid && w_accept;
        w_drop     = res_valid && !w_accept;
    end

    assign count    = r_count;
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elem     <= E11;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // A full buffer may overwrite the slot being popped this cycle;
            // the read path only ever sees the pre-edge contents.
            if (w_wr_en) begin
                r_mem[r_wr_ptr][0] <= c11;
                r_mem[r_wr_ptr][1] <= c12;
                r_mem[r_wr_ptr][2] <= c21;
                r_mem[r_wr_ptr][3] <= c22;
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end

            if (w_beat) begin
                if (r_elem == E22) begin
                    r_elem   <= E11;
                    r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                end else begin
                    r_elem <= elem_e'(r_elem + 2'd1);
                end
            end

            if (w_wr_en && !w_pop_last) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop_last) begin
                r_count <= r_count - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> ($stable(m_data) && $stable(m_idx)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_depth_cnt);

    a_drop_no_write: assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !w_accept) |=> ((r_count == $past(r_count)) && r_overflow));

endmodule : systolic_result_serializer
`default_nettype wire

// File: tb/tb_systolic_result_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_systolic_result_serializer
// Brief  : Self-checking bench: expected beats queued at stimulus time and
//          compared as the serializer emits them, plus directed corner cases.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_systolic_result_serializer;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 2;

    typedef logic [3:0][DATA_W-1:0] mat_t;   // [0]=c11 .. [3]=c22
    typedef struct { logic [DATA_W-1:0] data; logic [1:0] idx; } beat_t;
    typedef struct { mat_t m; mat_t exp; } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic              res_valid = 1'b0;
    logic              clr_overflow = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_idx;
    logic              m_last;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic              overflow;

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  tbl[3];
    mat_t  a_mat, b_mat, c_mat, d_mat;

    systolic_result_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .res_valid(res_valid), .clr_overflow(clr_overflow),
        .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mat(input mat_t m);
        for (int k = 0; k < 4; k++) exp_q.push_back('{data: m[k], idx: 2'(k)});
    endtask

    task automatic drive_mat(input mat_t m);
        c11 = m[0]; c12 = m[1]; c21 = m[2]; c22 = m[3];
        res_valid = 1'b1;
    endtask

    task automatic send(input mat_t m, input bit expect_accept);
        drive_mat(m);
        if (expect_accept) push_mat(m);
        tick();
        res_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                mon_b = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(mon_b.data));
                check("beat_idx",  32'(m_idx),  32'(mon_b.idx));
                check("beat_last", 32'(m_last), 32'(mon_b.idx == 2'd3));
            end
        end
    end

    initial begin
        tbl[0].m = {9'd50,  9'd43,  9'd22,  9'd19};  tbl[0].exp = {9'd50,  9'd43,  9'd22,  9'd19};
        tbl[1].m = {9'd1,   9'd256, 9'd0,   9'd511}; tbl[1].exp = {9'd1,   9'd256, 9'd0,   9'd511};
        tbl[2].m = {9'd236, 9'd258, 9'd142, 9'd155}; tbl[2].exp = {9'd236, 9'd258, 9'd142, 9'd155};
        a_mat = {9'd50,  9'd43,  9'd22,  9'd19};
        b_mat = {9'd236, 9'd258, 9'd142, 9'd155};
        c_mat = {9'd4,   9'd3,   9'd2,   9'd1};
        d_mat = {9'd400, 9'd300, 9'd200, 9'd100};

        // Reset state
        #12;
        check("rst_valid",    32'(m_valid),  0);
        check("rst_last",     32'(m_last),   0);
        check("rst_idx",      32'(m_idx),    0);
        check("rst_data",     32'(m_data),   0);
        check("rst_count",    32'(count),    0);
        check("rst_overflow", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table: single matrices, full-rate drain, 1-cycle latency
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_mat(tbl[i].m);
            push_mat(tbl[i].exp);
            tick();
            res_valid = 1'b0;
            check("tbl_latency_valid", 32'(m_valid), 1);
            check("tbl_first_data",    32'(m_data),  32'(tbl[i].exp[0]));
            check("tbl_first_idx",     32'(m_idx),   0);
            check("tbl_count",         32'(count),   1);
            repeat (4) tick();
            check("tbl_idle_valid", 32'(m_valid), 0);
            check("tbl_idle_count", 32'(count),   0);
            check("tbl_idle_data",  32'(m_data),  0);
            check("tbl_idle_last",  32'(m_last),  0);
        end

        // Stall pattern 0,1,0,1,...: each element held until accepted
        m_ready = 1'b0;
        send(a_mat, 1'b1);
        for (int i = 0; i < 8; i++) begin
            m_ready = i[0];
            #1;
            check("stall_hold", 32'(m_data), 32'(a_mat[i/2]));
            tick();
        end
        check("stall_done_valid", 32'(m_valid), 0);

        // Back-to-back results stream with no bubbles
        m_ready = 1'b1;
        drive_mat(a_mat); push_mat(a_mat); tick();
        drive_mat(b_mat); push_mat(b_mat); tick();
        res_valid = 1'b0;
        check("b2b_count_peak", 32'(count), 2);
        for (int i = 0; i < 7; i++) begin
            check("b2b_contiguous", 32'(m_valid), 1);
            tick();
        end
        check("b2b_done_valid", 32'(m_valid),  0);
        check("b2b_overflow",   32'(overflow), 0);

        // Overflow: third result dropped, set wins over clear, sticky, then clear
        m_ready = 1'b0;
        send(a_mat, 1'b1);
        send(b_mat, 1'b1);
        send(c_mat, 1'b0);
        check("ovf_count", 32'(count),    2);
        check("ovf_flag",  32'(overflow), 1);
        clr_overflow = 1'b1;
        send(d_mat, 1'b0);
        clr_overflow = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        m_ready = 1'b1;
        repeat (8) tick();
        check("ovf_drain_valid", 32'(m_valid),  0);
        check("ovf_sticky",      32'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full buffer accepts a write in the same cycle as the last pop
        m_ready = 1'b0;
        send(a_mat, 1'b1);
        send(b_mat, 1'b1);
        check("full_count", 32'(count), 2);
        m_ready = 1'b1;
        repeat (3) tick();
        check("full_idx3",  32'(m_idx),  3);
        check("full_last",  32'(m_last), 1);
        send(c_mat, 1'b1);
        check("full_pop_count",    32'(count),    2);
        check("full_pop_overflow", 32'(overflow), 0);
        repeat (8) tick();
        check("full_done_valid", 32'(m_valid), 0);
        check("full_done_count", 32'(count),   0);

        // Async reset in the middle of a drain
        send(a_mat, 1'b1);
        repeat (2) tick();
        check("rstmid_idx", 32'(m_idx), 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(m_valid), 0);
        check("rstmid_count", 32'(count),   0);
        check("rstmid_data",  32'(m_data),  0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(d_mat, 1'b1);
        check("rstmid_restart_idx",  32'(m_idx),  0);
        check("rstmid_restart_data", 32'(m_data), 32'(d_mat[0]));
        repeat (4) tick();
        check("rstmid_done_valid", 32'(m_valid), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_systolic_result_serializer
`default_nettype wire
